lp805x_sfrbus_master: RTL and testbench

- CPU-side initiator for the 29-bit SFR peripheral bus. It takes byte and bit access requests from the core through a valid/ready queue.
- It encodes each request into sfr_bus cycles and collects read data from the shared tri-state data_out/bit_out return lines of all peripherals.
- It returns read results through a valid/ready response port.
- It sits between the core's SFR access logic and every MMIO peripheral, such as timers and ports.

---
 rtl/lp805x_sfrbus_master.sv | 133 +++++++++++++
 tb/tb_lp805x_sfrbus_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lp805x_sfrbus_master.sv
// rtl/lp805x_sfrbus_master.sv - CPU-side SFR bus initiator with request queue and read response port
module lp805x_sfrbus_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_bit,
  input  logic [7:0]  req_addr,
  input  logic [7:0]  req_wdata,
  input  logic        req_wbit,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_bit,
  output logic [28:0] sfr_bus,
  input  logic [7:0]  sfr_data,
  input  logic        sfr_bitv,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_WAIT, RESP} state_t;

  // Queue entry layout: {write, bit, addr[7:0], wdata[7:0], wbit}
  localparam int EW = 19;

  state_t state, next_state;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [FIFO_AW:0] wptr, rptr;
  logic             full, empty, push, pop;
  logic [EW-1:0]    head;

  logic             cur_bit;
  logic [7:0]       cur_addr;
  logic [7:0]       cur_wdata;
  logic             cur_wbit;

  assign empty     = (wptr == rptr);
  assign full      = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                     (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign head      = mem[rptr[FIFO_AW-1:0]];
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) || !empty;

  // Queue storage: written on accept, no reset needed since pointers gate validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[FIFO_AW-1:0]] <= {req_write, req_bit, req_addr, req_wdata, req_wbit};
    end
  end

  // Queue pointers; extra MSB distinguishes full from empty across wrap-around
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (FIFO_AW+1)'(1);
      if (pop)  rptr <= rptr + (FIFO_AW+1)'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FSM next state, queue pop and bus encoding; bus is all-zero outside active states
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    sfr_bus    = '0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = head[18] ? WR : RD_ADDR;
        end
      end
      WR: begin
        sfr_bus    = {1'b1, 1'b0, cur_bit, 1'b0, cur_addr, 8'h00, cur_wdata, cur_wbit};
        next_state = IDLE;
      end
      RD_ADDR: begin
        sfr_bus    = {1'b0, 1'b1, 1'b0, cur_bit, 8'h00, cur_addr, 8'h00, 1'b0};
        next_state = RD_WAIT;
      end
      RD_WAIT: begin
        // Address held so the peripheral keeps driving its registered data
        sfr_bus    = {1'b0, 1'b0, 1'b0, cur_bit, 8'h00, cur_addr, 8'h00, 1'b0};
        next_state = RESP;
      end
      RESP: begin
        if (rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Current request capture on pop
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_bit   <= 1'b0;
      cur_addr  <= 8'h00;
      cur_wdata <= 8'h00;
      cur_wbit  <= 1'b0;
    end else if (pop) begin
      cur_bit   <= head[17];
      cur_addr  <= head[16:9];
      cur_wdata <= head[8:1];
      cur_wbit  <= head[0];
    end
  end

  // Read data capture at the end of RD_WAIT; the unused half of the result is forced to zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data <= 8'h00;
      rsp_bit  <= 1'b0;
    end else if (state == RD_WAIT) begin
      rsp_data <= cur_bit ? 8'h00 : sfr_data;
      rsp_bit  <= cur_bit ? sfr_bitv : 1'b0;
    end
  end

endmodule

// File: tb/tb_lp805x_sfrbus_master.sv
// tb/tb_lp805x_sfrbus_master.sv - directed self-checking bench for lp805x_sfrbus_master
module tb_lp805x_sfrbus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_bit, req_wbit;
  logic [7:0]  req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_bit;
  logic [7:0]  rsp_data;
  logic [28:0] sfr_bus;
  logic [7:0]  sfr_data;
  logic        sfr_bitv;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  lp805x_sfrbus_master #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_bit(req_bit), .req_addr(req_addr), .req_wdata(req_wdata), .req_wbit(req_wbit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_bit(rsp_bit),
    .sfr_bus(sfr_bus), .sfr_data(sfr_data), .sfr_bitv(sfr_bitv), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model peripheral register file: writes on wr, registers read data on rd
  logic [7:0] regs [0:255];
  logic [7:0] rd_q = 8'h00;
  logic       rbit_q = 1'b0;
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = 8'h00, poke_data = 8'h00;
  wire  [7:0] wa = sfr_bus[24:17];
  wire  [7:0] ra = sfr_bus[16:9];

  assign sfr_data = rd_q;
  assign sfr_bitv = rbit_q;

  always @(posedge clk) begin
    if (poke_en) regs[poke_addr] <= poke_data;
    if (sfr_bus[28]) begin
      if (sfr_bus[26]) regs[{wa[7:3], 3'b000}][wa[2:0]] <= sfr_bus[0];
      else             regs[wa] <= sfr_bus[8:1];
    end
    if (sfr_bus[27]) begin
      rd_q   <= regs[ra];
      rbit_q <= regs[{ra[7:3], 3'b000}][ra[2:0]];
    end
  end

  function automatic logic [28:0] bus(input logic wr, input logic rd, input logic wb, input logic rb,
                                      input logic [7:0] wad, input logic [7:0] rad,
                                      input logic [7:0] di, input logic bi);
    return {wr, rd, wb, rb, wad, rad, di, bi};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  task automatic set_req(input logic w, input logic b, input logic [7:0] a,
                         input logic [7:0] wd, input logic wb);
    req_valid = 1'b1;
    req_write = w;
    req_bit   = b;
    req_addr  = a;
    req_wdata = wd;
    req_wbit  = wb;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bit = 1'b0;
    req_addr = 8'h00; req_wdata = 8'h00; req_wbit = 1'b0; rsp_ready = 1'b1;
    tick(); tick();
    n_checks++; if (sfr_bus !== 29'h0) begin n_fail++; $display("FAIL reset_bus got %h exp 0", sfr_bus); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h00 || rsp_bit !== 1'b0) begin n_fail++; $display("FAIL reset_rsp got %h/%b exp 00/0", rsp_data, rsp_bit); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst = 1'b0;
    tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_byte_write();
    set_req(1'b1, 1'b0, 8'h8C, 8'hA5, 1'b0);
    tick();
    req_valid = 1'b0;
    n_checks++; if (sfr_bus !== 29'h0 || busy !== 1'b1) begin n_fail++; $display("FAIL bw_queued bus %h busy %b exp 0/1", sfr_bus, busy); end
    tick();
    n_checks++; if (sfr_bus !== bus(1,0,0,0,8'h8C,8'h00,8'hA5,0)) begin n_fail++; $display("FAIL bw_bus got %h exp %h", sfr_bus, bus(1,0,0,0,8'h8C,8'h00,8'hA5,0)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (sfr_bus !== 29'h0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bw_after bus %h rsp_valid %b exp 0/0", sfr_bus, rsp_valid); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bw_idle busy %b exp 0", busy); end
  endtask

  task automatic test_byte_read();
    poke(8'h8C, 8'h3C);
    set_req(1'b0, 1'b0, 8'h8C, 8'h00, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    n_checks++; if (sfr_bus !== bus(0,1,0,0,8'h00,8'h8C,8'h00,0)) begin n_fail++; $display("FAIL br_rdaddr got %h exp %h", sfr_bus, bus(0,1,0,0,8'h00,8'h8C,8'h00,0)); end
    tick();
    n_checks++; if (sfr_bus !== bus(0,0,0,0,8'h00,8'h8C,8'h00,0) || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL br_rdwait bus %h rsp_valid %b", sfr_bus, rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C || rsp_bit !== 1'b0) begin n_fail++; $display("FAIL br_rsp got %b/%h/%b exp 1/3c/0", rsp_valid, rsp_data, rsp_bit); end
    n_checks++; if (sfr_bus !== 29'h0) begin n_fail++; $display("FAIL br_resp_bus got %h exp 0", sfr_bus); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL br_rsp_clear got %b exp 0", rsp_valid); end
  endtask

  task automatic test_bit_access();
    poke(8'h88, 8'hF0);
    poke(8'h8B, 8'h77);
    set_req(1'b1, 1'b1, 8'h8B, 8'h00, 1'b1);
    tick();
    set_req(1'b0, 1'b1, 8'h8B, 8'h00, 1'b0);
    tick();
    req_valid = 1'b0;
    n_checks++; if (sfr_bus !== bus(1,0,1,0,8'h8B,8'h00,8'h00,1)) begin n_fail++; $display("FAIL bit_wr got %h exp %h", sfr_bus, bus(1,0,1,0,8'h8B,8'h00,8'h00,1)); end
    n_checks++; if (sfr_bus[24:20] !== 5'h11 || sfr_bus[19:17] !== 3'd3) begin n_fail++; $display("FAIL bit_wr_fields got %h/%0d exp 11/3", sfr_bus[24:20], sfr_bus[19:17]); end
    tick();
    tick();
    n_checks++; if (sfr_bus !== bus(0,1,0,1,8'h00,8'h8B,8'h00,0)) begin n_fail++; $display("FAIL bit_rd got %h exp %h", sfr_bus, bus(0,1,0,1,8'h00,8'h8B,8'h00,0)); end
    tick();
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_bit !== 1'b1 || rsp_data !== 8'h00) begin n_fail++; $display("FAIL bit_rsp got %b/%b/%h exp 1/1/00", rsp_valid, rsp_bit, rsp_data); end
    tick();
  endtask

  task automatic test_backpressure();
    poke(8'h90, 8'h5A);
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, 8'h90, 8'h00, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_%0d got %b exp 1", k, req_ready); end
      set_req(1'b1, 1'b0, 8'hA0 + 8'(k), 8'h01 + 8'(k), 1'b0);
      tick();
    end
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full got %b exp 0", req_ready); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A) begin n_fail++; $display("FAIL bp_rsp got %b/%h exp 1/5a", rsp_valid, rsp_data); end
    set_req(1'b0, 1'b0, 8'hA2, 8'h00, 1'b0);
    tick(); tick();
    n_checks++; if (req_ready !== 1'b0 || sfr_bus !== 29'h0 || rsp_valid !== 1'b1 || rsp_data !== 8'h5A) begin n_fail++; $display("FAIL bp_stall ready %b bus %h rsp %b/%h", req_ready, sfr_bus, rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    tick();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_release rsp %b ready %b exp 0/0", rsp_valid, req_ready); end
    tick();
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_unfull got %b exp 1", req_ready); end
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (sfr_bus !== bus(1,0,0,0,8'hA0 + 8'(k),8'h00,8'h01 + 8'(k),0)) begin n_fail++; $display("FAIL bp_order_%0d got %h exp %h", k, sfr_bus, bus(1,0,0,0,8'hA0 + 8'(k),8'h00,8'h01 + 8'(k),0)); end
      tick();
      if (k == 0) req_valid = 1'b0;
      n_checks++; if (sfr_bus !== 29'h0) begin n_fail++; $display("FAIL bp_gap_%0d got %h exp 0", k, sfr_bus); end
      tick();
    end
    n_checks++; if (sfr_bus !== bus(0,1,0,0,8'h00,8'hA2,8'h00,0)) begin n_fail++; $display("FAIL bp_held_rd got %h exp %h", sfr_bus, bus(0,1,0,0,8'h00,8'hA2,8'h00,0)); end
    tick(); tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h03) begin n_fail++; $display("FAIL bp_held_rsp got %b/%h exp 1/03", rsp_valid, rsp_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    set_req(1'b1, 1'b0, 8'hB0, 8'h55, 1'b0);
    tick();
    set_req(1'b0, 1'b0, 8'hB0, 8'h00, 1'b0);
    tick();
    req_valid = 1'b0;
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_timeout rsp_valid %b exp 1", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h55) begin n_fail++; $display("FAIL b2b_data got %h exp 55", rsp_data); end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(1'b0, 1'b0, 8'hC0, 8'h00, 1'b0);
    tick();
    set_req(1'b1, 1'b0, 8'hC8, 8'h11, 1'b0);
    tick();
    set_req(1'b1, 1'b0, 8'hC9, 8'h22, 1'b0);
    tick();
    req_valid = 1'b0;
    n_checks++; if (sfr_bus !== bus(0,0,0,0,8'h00,8'hC0,8'h00,0)) begin n_fail++; $display("FAIL rm_rdwait got %h exp %h", sfr_bus, bus(0,0,0,0,8'h00,8'hC0,8'h00,0)); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (sfr_bus !== 29'h0 || rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_after bus %h rsp %b busy %b ready %b exp 0/0/0/1", sfr_bus, rsp_valid, busy, req_ready); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (sfr_bus !== 29'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rm_quiet_%0d bus %h busy %b exp 0/0", i, sfr_bus, busy); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_write();
    test_byte_read();
    test_bit_access();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
